// File: rtl/mac_seq_pkg.sv
// mac_seq_pkg: shared definitions for the MAC job sequencer.
//   - FSM state encodings (plain 3-bit constants)
//   - MAC CFU function ids
//   - wrapping 32-bit add used for the optional result bias
package mac_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_CFG      = 3'd1;
  localparam state_t ST_CFG_WAIT = 3'd2;
  localparam state_t ST_RD       = 3'd3;
  localparam state_t ST_ISSUE    = 3'd4;
  localparam state_t ST_WAIT     = 3'd5;
  localparam state_t ST_DONE     = 3'd6;

  localparam logic [9:0] FID_MAC        = 10'd0;
  localparam logic [9:0] FID_SET_OFFSET = 10'd8;

  // Two's-complement add; overflow wraps mod 2^32.
  function automatic logic [31:0] add_wrap(input logic [31:0] a, input logic [31:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/mac_job_sequencer.sv
// mac_job_sequencer: runs one dot-product job through the SIMD int8 MAC CFU.
//
// A job first sends a set-offset command (which also clears the MAC
// accumulator), then for each word reads one activation and one weight word
// from two synchronous SRAM ports and issues an accumulate command. The last
// accumulator value returned by the MAC is presented on the result port.
//
// Optional build macro MAC_SEQ_BIAS_EN: adds input cfg_bias (signed 32-bit,
// latched at start) and the result becomes acc + bias, wrapping mod 2^32.
//
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   start / start_ready     job request handshake (ready only in IDLE)
//   cfg_len                 number of 32-bit words (4 int8 lanes each)
//   cfg_base_a / cfg_base_b activation / weight base word addresses
//   cfg_offset              input offset for the set-offset command
//   cfg_bias                (MAC_SEQ_BIAS_EN only) result bias
//   busy                    high whenever not IDLE
//   mem_rd_en, mem_addr_*   SRAM read strobe (shared) and addresses
//   mem_rdata_*             SRAM read data, valid the cycle after mem_rd_en
//   mac_cmd_*               command handshake to the MAC
//   mac_rsp_*               response handshake from the MAC
//   result_valid/_ready     job result handshake, result value
module mac_job_sequencer
  import mac_seq_pkg::*;
#(
  parameter int AW    = 10,
  parameter int LEN_W = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  output logic                start_ready,
  input  logic [LEN_W-1:0]    cfg_len,
  input  logic [AW-1:0]       cfg_base_a,
  input  logic [AW-1:0]       cfg_base_b,
  input  logic [15:0]         cfg_offset,
`ifdef MAC_SEQ_BIAS_EN
  input  logic signed [31:0]  cfg_bias,
`endif
  output logic                busy,
  output logic                mem_rd_en,
  output logic [AW-1:0]       mem_addr_a,
  output logic [AW-1:0]       mem_addr_b,
  input  logic [31:0]         mem_rdata_a,
  input  logic [31:0]         mem_rdata_b,
  output logic                mac_cmd_valid,
  input  logic                mac_cmd_ready,
  output logic [9:0]          mac_cmd_function_id,
  output logic [31:0]         mac_cmd_inputs_0,
  output logic [31:0]         mac_cmd_inputs_1,
  input  logic                mac_rsp_valid,
  output logic                mac_rsp_ready,
  input  logic [31:0]         mac_rsp_outputs_0,
  output logic                result_valid,
  input  logic                result_ready,
  output logic [31:0]         result
);

  state_t               state;
  logic [LEN_W-1:0]     idx;
  logic [LEN_W-1:0]     len;
  logic [AW-1:0]        base_a;
  logic [AW-1:0]        base_b;
  logic [15:0]          offset;
  logic [31:0]          acc;
`ifdef MAC_SEQ_BIAS_EN
  logic signed [31:0]   bias;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      idx    <= '0;
      len    <= '0;
      base_a <= '0;
      base_b <= '0;
      offset <= '0;
      acc    <= '0;
`ifdef MAC_SEQ_BIAS_EN
      bias   <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            len    <= cfg_len;
            base_a <= cfg_base_a;
            base_b <= cfg_base_b;
            offset <= cfg_offset;
`ifdef MAC_SEQ_BIAS_EN
            bias   <= cfg_bias;
`endif
            idx    <= '0;
            state  <= ST_CFG;
          end
        end
        ST_CFG: begin
          if (mac_cmd_ready) state <= ST_CFG_WAIT;
        end
        ST_CFG_WAIT: begin
          if (mac_rsp_valid) begin
            acc   <= '0;
            state <= (len == '0) ? ST_DONE : ST_RD;
          end
        end
        ST_RD: begin
          state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          // Read data is held by the SRAM until the next read, and no read
          // is issued here, so the operands stay stable while stalled.
          if (mac_cmd_ready) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mac_rsp_valid) begin
            acc   <= mac_rsp_outputs_0;
            idx   <= idx + LEN_W'(1);
            state <= (idx == len - LEN_W'(1)) ? ST_DONE : ST_RD;
          end
        end
        ST_DONE: begin
          if (result_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign start_ready   = (state == ST_IDLE);
  assign busy          = (state != ST_IDLE);
  // Responses are always accepted; those outside CFG_WAIT/WAIT are dropped.
  assign mac_rsp_ready = reset_n;

  // Addresses wrap mod 2^AW; config and idx are zero after reset.
  assign mem_rd_en  = (state == ST_RD);
  assign mem_addr_a = base_a + AW'(idx);
  assign mem_addr_b = base_b + AW'(idx);

  always_comb begin
    mac_cmd_valid       = 1'b0;
    mac_cmd_function_id = FID_MAC;
    mac_cmd_inputs_0    = '0;
    mac_cmd_inputs_1    = '0;
    if (state == ST_CFG) begin
      mac_cmd_valid       = 1'b1;
      mac_cmd_function_id = FID_SET_OFFSET;
      mac_cmd_inputs_0    = {16'h0000, offset};
    end else if (state == ST_ISSUE) begin
      mac_cmd_valid       = 1'b1;
      mac_cmd_function_id = FID_MAC;
      mac_cmd_inputs_0    = mem_rdata_a;
      mac_cmd_inputs_1    = mem_rdata_b;
    end
  end

  assign result_valid = (state == ST_DONE);
`ifdef MAC_SEQ_BIAS_EN
  assign result = (state == ST_DONE) ? add_wrap(acc, bias) : 32'h0;
`else
  assign result = (state == ST_DONE) ? acc : 32'h0;
`endif

endmodule

// File: doc/mac_job_sequencer.md
Name: mac_job_sequencer

Overview:
- Sequences one dot-product job through the SIMD int8 MAC CFU (function_id 0 = accumulate, function_id 8 = set input offset and clear accumulator).
- A job is: input offset, word count, and two word-address bases.
- The block fetches packed int8 words from two synchronous SRAM ports, drives the MAC cmd/rsp handshake, and returns the final accumulator on a valid/ready result port.
- It sits between the job-dispatch logic and the MAC datapath.

Parameters:
- AW, 10, word-address width of both SRAM ports.
- LEN_W, 10, width of the job word count.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- start  in  1  job request; accepted when start and start_ready are both high
- start_ready  out  1  high only in IDLE
- cfg_len  in  LEN_W  number of 32-bit words (4 int8 lanes each)
- cfg_base_a  in  AW  activation base word address
- cfg_base_b  in  AW  weight base word address
- cfg_offset  in  16  input offset, sent in inputs_0[15:0] of the set-offset command
- busy  out  1  not IDLE
- mem_rd_en  out  1  SRAM read strobe, both ports
- mem_addr_a  out  AW  activation address
- mem_addr_b  out  AW  weight address
- mem_rdata_a  in  32  activation data; valid the cycle after mem_rd_en, held until the next read
- mem_rdata_b  in  32  weight data; same timing as mem_rdata_a
- mac_cmd_valid  out  1  command valid to the MAC
- mac_cmd_ready  in  1  MAC command ready
- mac_cmd_function_id  out  10  MAC function id
- mac_cmd_inputs_0  out  32  MAC operand 0
- mac_cmd_inputs_1  out  32  MAC operand 1
- mac_rsp_valid  in  1  MAC response valid
- mac_rsp_ready  out  1  response ready to the MAC
- mac_rsp_outputs_0  in  32  MAC accumulator value
- result_valid  out  1  job result valid
- result_ready  in  1  job result accepted
- result  out  32  job result

Behaviour:
- Reset (reset_n low at a clock edge) forces IDLE and clears idx, latched config and acc.
  - Outputs during/after reset: start_ready=1, busy=0, mem_rd_en=0, mac_cmd_valid=0, result_valid=0, result=0, addresses 0, function_id 0.
- mac_rsp_ready = 1 whenever reset_n is high, in every state. Responses arriving outside CFG_WAIT/WAIT are consumed and ignored.
- IDLE: on start&start_ready, latch the cfg_* inputs, set idx=0, go to CFG.
- CFG: mac_cmd_valid=1, function_id=10'd8, inputs_0={16'h0,offset}, inputs_1=0. On mac_cmd_ready go to CFG_WAIT, otherwise hold all outputs stable.
- CFG_WAIT: on mac_rsp_valid, acc<=0. If len==0 go to DONE, else go to RD.
- RD: mem_rd_en=1, mem_addr_a=base_a+idx, mem_addr_b=base_b+idx (mod 2^AW, wrap allowed). Go to ISSUE.
- ISSUE: mac_cmd_valid=1, function_id=0, inputs_0=mem_rdata_a, inputs_1=mem_rdata_b.
  - Hold all outputs stable until mac_cmd_ready; then go to WAIT.
  - No SRAM read is issued while in ISSUE.
- WAIT: on mac_rsp_valid, acc<=mac_rsp_outputs_0 and idx<=idx+1. If idx==len-1 go to DONE, else go to RD.
- DONE: result_valid=1, result=acc, held stable until result_ready, then go to IDLE. start is not sampled in DONE.
- Latency with the MAC always ready:
  - start accepted at cycle 0; CFG at 1; CFG_WAIT at 2.
  - 3 cycles per word.
  - result_valid first high at cycle 3+3*len (len=0 gives cycle 3).
- Arithmetic: accumulation happens in the MAC; the sequencer only captures. len is unsigned, with maximum 2^LEN_W-1 words.
- Simultaneous start while busy: ignored (start_ready=0).
- Reset mid-job: abort immediately, no result emitted. The MAC has its own reset; the next job's set-offset command re-clears its accumulator.

Optional Feature:
- Macro MAC_SEQ_BIAS_EN.
- Defined:
  - Adds port cfg_bias (in, 32, signed), latched at start.
  - result = acc + bias, wrapping mod 2^32, computed combinationally in DONE.
  - len==0 gives result = bias.
- Undefined: port absent, result = acc.

Decomposition:
- Package mac_seq_pkg:
  - state enum (IDLE, CFG, CFG_WAIT, RD, ISSUE, WAIT, DONE)
  - FID_MAC=10'd0, FID_SET_OFFSET=10'd8
- Single module; no sub-module warranted. The address counter is inline.

Test Plan:
- len=1, offset=128, A[0]=0x01020304, B[0]=0x01010101, MAC model always ready -> result=522, result_valid at cycle 6.
- len=0, offset=5 -> exactly one function_id=8 command, no mem_rd_en, result=0 at cycle 3; with MAC_SEQ_BIAS_EN and bias=-7 -> result=0xFFFFFFF9.
- len=4, base_a=1022, base_b=0, AW=10 -> addresses A: 1022,1023,0,1 and B: 0,1,2,3; result equals the sum of the four MAC dot products.
- mac_cmd_ready held low for 5 cycles in ISSUE -> cmd_valid, function_id and inputs stable throughout; total latency +5; result unchanged.
- result_ready low for 10 cycles in DONE -> result stable, start_ready=0, a start pulse is ignored; after handshake, IDLE next cycle.
- reset_n low for 1 cycle at word 2 of len=8 -> next cycle IDLE, all outputs at reset values, no result_valid; a new job then completes correctly.
